mult_seq_ctrl: RTL and testbench

//  Sequencing controller for the 8-bit shift-add multiplier datapath.

---
 rtl/mult_pkg.sv | 26 ++
 rtl/mult_seq_ctrl_if.sv | 29 ++
 rtl/mult_shift_dp.sv | 52 +++++
 rtl/mult_seq_ctrl.sv | 106 ++++++++++
 tb/tb_mult_seq_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared constants, FSM state type and operand helpers for the sequential
// shift-add multiplier (mult_seq_ctrl and its datapath mult_shift_dp).
package mult_pkg;

    localparam int OP_W  = 8;                   // two's-complement operand width
    localparam int MAG_W = OP_W - 1;            // magnitude width = iterations per full run
    localparam int RES_W = 2 * (OP_W - 1);      // product magnitude width
    localparam int CNT_W = $clog2(MAG_W + 1);   // iteration counter width

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Sign-magnitude conversion of the low bits; 0x80 maps to 0 and is flagged separately.
    function automatic logic [MAG_W-1:0] to_mag(input logic [OP_W-1:0] x);
        return x[OP_W-1] ? (~x[MAG_W-1:0] + MAG_W'(1)) : x[MAG_W-1:0];
    endfunction

    // True for the one operand value whose magnitude does not fit in MAG_W bits.
    function automatic logic is_min_neg(input logic [OP_W-1:0] x);
        return x == {1'b1, {MAG_W{1'b0}}};
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Command/result bundle between the operand source, the multiplier controller
// and the result display logic.
interface mult_seq_ctrl_if
    import mult_pkg::*;
();

    logic             start;
    logic [OP_W-1:0]  multiplier;
    logic [OP_W-1:0]  multiplicand;
    logic             busy;
    logic             done;
    logic [RES_W-1:0] result;
    logic             sign;
    logic             zflag;
    logic             err;

    // Command source side
    modport master (
        output start, multiplier, multiplicand,
        input  busy, done, result, sign, zflag, err
    );

    // Multiplier controller side
    modport slave (
        input  start, multiplier, multiplicand,
        output busy, done, result, sign, zflag, err
    );

endinterface

// File: rtl/mult_shift_dp.sv
// Shift-add datapath: magnitude registers, shifting multiplier/multiplicand,
// accumulator and iteration counter. Sequenced by load/step from the FSM.
module mult_shift_dp
    import mult_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [OP_W-1:0]  multiplier,
    input  logic [OP_W-1:0]  multiplicand,
    output logic [RES_W-1:0] acc,
    output logic             mplier_zero,
    output logic             cnt_last,
    output logic             cnt_zero
);

    logic [MAG_W-1:0] mplier_sh;
    logic [RES_W-1:0] mcand_sh;
    logic [CNT_W-1:0] cnt;

    // Load magnitudes on an accepted start, then one add/shift iteration per step.
    always_ff @(posedge clock) begin
        // NOTE: the datapath registers are few, so they take the reset too; an
        // aborted run then leaves no stale partial product behind.
        if (!reset_n) begin
            mplier_sh <= '0;
            mcand_sh  <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else if (load) begin
            mplier_sh <= to_mag(multiplier);
            mcand_sh  <= RES_W'(to_mag(multiplicand));
            acc       <= '0;
            cnt       <= '0;
        end else if (step) begin
            // NOTE: non-blocking assignments, so every right-hand side below
            // sees the pre-edge values and the statement order does not matter.
            if (mplier_sh[0]) begin
                acc <= acc + mcand_sh;
            end
            mplier_sh <= mplier_sh >> 1;
            mcand_sh  <= mcand_sh << 1;
            cnt       <= cnt + CNT_W'(1);
        end
    end

    assign mplier_zero = (mplier_sh == '0);
    assign cnt_last    = (cnt == CNT_W'(MAG_W));
    assign cnt_zero    = (cnt == '0);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the 8-bit shift-add multiplier.
// IDLE -> RUN -> DONE -> IDLE; all interface outputs are registered.
// Optional build macro EARLY_TERM_EN: leave RUN as soon as the shifted
// multiplier has run out of set bits (after at least one iteration).
module mult_seq_ctrl
    import mult_pkg::*;
(
    input  logic           clock,
    input  logic           reset_n,
    mult_seq_ctrl_if.slave bus
);

    state_t           state;
    logic             busy_q;
    logic             done_q;
    logic [RES_W-1:0] result_q;
    logic             sign_q;
    logic             zflag_q;
    logic             err_q;
    logic             sign_raw;

    logic [RES_W-1:0] acc;
    logic             mplier_zero;
    logic             cnt_last;
    logic             cnt_zero;
    logic             load;
    logic             step;
    logic             run_exit;

    // An invalid (0x80) operand still spends one RUN edge, so err runs end at E2.
`ifdef EARLY_TERM_EN
    assign run_exit = cnt_last || (!cnt_zero && (err_q || mplier_zero));
`else
    assign run_exit = cnt_last || (!cnt_zero && err_q);
    // The zero-multiplier status only matters for early termination.
    logic unused_mplier_zero;
    assign unused_mplier_zero = mplier_zero;
`endif

    assign load = (state == S_IDLE) && bus.start;
    assign step = (state == S_RUN) && !run_exit;

    mult_shift_dp u_dp (
        .clock        (clock),
        .reset_n      (reset_n),
        .load         (load),
        .step         (step),
        .multiplier   (bus.multiplier),
        .multiplicand (bus.multiplicand),
        .acc          (acc),
        .mplier_zero  (mplier_zero),
        .cnt_last     (cnt_last),
        .cnt_zero     (cnt_zero)
    );

    // Control FSM with registered busy/done and result outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            sign_q   <= 1'b0;
            zflag_q  <= 1'b0;
            err_q    <= 1'b0;
            sign_raw <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state    <= S_RUN;
                        busy_q   <= 1'b1;
                        err_q    <= is_min_neg(bus.multiplier) || is_min_neg(bus.multiplicand);
                        sign_raw <= bus.multiplier[OP_W-1] ^ bus.multiplicand[OP_W-1];
                    end
                end
                S_RUN: begin
                    if (run_exit) begin
                        state    <= S_DONE;
                        done_q   <= 1'b1;
                        result_q <= acc;
                        zflag_q  <= (acc == '0);
                        sign_q   <= sign_raw && (acc != '0);
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.sign   = sign_q;
    assign bus.zflag  = zflag_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed corner cases plus random
// operands, compared against an arithmetic reference model.
// Honours EARLY_TERM_EN when defined for the build.
module tb_mult_seq_ctrl;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_pass;

    mult_seq_ctrl_if bus ();

    mult_seq_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: plain signed arithmetic; latency counted in edges after the accepting edge.
    function automatic void ref_model(input logic [7:0] a, input logic [7:0] b,
                                      output int res, output bit sgn, output bit zf,
                                      output bit er, output int lat);
        int sa, sb, ma, mb, bits, v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        er = (sa == -128) || (sb == -128);
        res = er ? 0 : ma * mb;
        zf = (res == 0);
        sgn = !zf && ((sa < 0) != (sb < 0));
`ifdef EARLY_TERM_EN
        bits = 0;
        v = ma;
        while (v > 0) begin
            bits++;
            v = v / 2;
        end
        lat = er ? 2 : ((bits < 1) ? 1 : bits) + 1;
`else
        v = 0;
        bits = 0;
        lat = er ? 2 : 8;
`endif
    endfunction

    // Run one multiplication at the earliest accepting edge and check every output.
    task automatic exec_op(input string tag, input logic [7:0] a, input logic [7:0] b);
        int e_res, e_lat, lat, guard;
        bit e_sgn, e_zf, e_er;
        ref_model(a, b, e_res, e_sgn, e_zf, e_er, e_lat);
        guard = 0;
        @(negedge clock);
        while (bus.busy !== 1'b0 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        bus.start = 1'b1;
        bus.multiplier = a;
        bus.multiplicand = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.multiplier = 8'($urandom);
        bus.multiplicand = 8'($urandom);
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL %s busy_after_accept: got %b expected 1", tag, bus.busy);
        else n_pass++;
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (bus.done !== 1'b1 && lat < 40);
        n_checks++;
        if (lat != e_lat) $display("FAIL %s latency: got %0d edges expected %0d", tag, lat, e_lat);
        else n_pass++;
        n_checks++;
        if (bus.result !== 14'(e_res)) $display("FAIL %s result: got %0d expected %0d", tag, bus.result, e_res);
        else n_pass++;
        n_checks++;
        if (bus.sign !== e_sgn || bus.zflag !== e_zf || bus.err !== e_er || bus.busy !== 1'b1)
            $display("FAIL %s flags(sign,zflag,err,busy): got %b%b%b%b expected %b%b%b1",
                     tag, bus.sign, bus.zflag, bus.err, bus.busy, e_sgn, e_zf, e_er);
        else n_pass++;
        @(posedge clock);
        #1;
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 14'(e_res))
            $display("FAIL %s after_done(done,busy,result): got %b %b %0d expected 0 0 %0d",
                     tag, bus.done, bus.busy, bus.result, e_res);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.multiplier = 8'h00;
        bus.multiplicand = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.result, bus.sign, bus.zflag, bus.err} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b result=%0d sign=%b zflag=%b err=%b expected all 0",
                     bus.busy, bus.done, bus.result, bus.sign, bus.zflag, bus.err);
        else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] va [7] = '{8'h03, 8'hFD, 8'h81, 8'h00, 8'h7F, 8'h40, 8'h01};
        logic [7:0] vb [7] = '{8'h05, 8'h05, 8'h81, 8'hFB, 8'h80, 8'hFF, 8'h7F};
        for (int i = 0; i < 7; i++) exec_op($sformatf("directed%0d", i), va[i], vb[i]);
    endtask

    task automatic test_err();
        exec_op("err_a80", 8'h80, 8'h05);
        exec_op("err_clear", 8'h06, 8'hF9);
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clock);
        bus.start = 1'b1;
        bus.multiplier = 8'h07;
        bus.multiplicand = 8'h09;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        bus.start = 1'b1;
        bus.multiplier = 8'h02;
        bus.multiplicand = 8'h02;
        @(negedge clock);
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        n_checks++;
        if (bus.done !== 1'b1 || bus.result !== 14'd63)
            $display("FAIL ignore_start_result: got done=%b result=%0d expected done=1 result=63", bus.done, bus.result);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            n_checks++;
            if (bus.busy !== 1'b0 || bus.result !== 14'd63)
                $display("FAIL ignore_start_no_queue: got busy=%b result=%0d expected busy=0 result=63", bus.busy, bus.result);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        exec_op("b2b_first", 8'h07, 8'h09);
        exec_op("b2b_second", 8'h02, 8'h02);
        exec_op("b2b_third", 8'hF6, 8'h0C);
    endtask

    task automatic test_midrun_reset();
        exec_op("pre_reset", 8'h0B, 8'hF3);
        @(negedge clock);
        bus.start = 1'b1;
        bus.multiplier = 8'h25;
        bus.multiplicand = 8'h13;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.result, bus.sign, bus.zflag, bus.err} !== '0)
            $display("FAIL midrun_reset: got busy=%b done=%b result=%0d sign=%b zflag=%b err=%b expected all 0",
                     bus.busy, bus.done, bus.result, bus.sign, bus.zflag, bus.err);
        else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        exec_op("post_reset", 8'h25, 8'h13);
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        int e_res, e_lat, idle;
        bit e_sgn, e_zf, e_er;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (i % 8 == 3) a = 8'h00;
            if (i % 8 == 5) b = 8'h80;
            if (i % 8 == 6) a = 8'($urandom_range(1, 15));
            exec_op($sformatf("random%0d", i), a, b);
            ref_model(a, b, e_res, e_sgn, e_zf, e_er, e_lat);
            idle = $urandom_range(0, 3);
            repeat (idle) @(posedge clock);
            #1;
            n_checks++;
            if (bus.result !== 14'(e_res) || bus.err !== e_er || bus.busy !== 1'b0)
                $display("FAIL random%0d_hold: got result=%0d err=%b busy=%b expected result=%0d err=%b busy=0",
                         i, bus.result, bus.err, bus.busy, e_res, e_er);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        test_reset();
        test_directed();
        test_err();
        test_ignore_start();
        test_back_to_back();
        test_midrun_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
